// File: rtl/calc_md_seq_if.sv
// -----------------------------------------------------------------------------
// calc_md_seq_if
//   Request/response bundle for the calc_md_seq sequenced calculator.
//
//   Signals (W = operand width):
//     start  1  request, honoured only while the calculator is idle
//     op     3  operation select (add/sub/and/xor/mul/div, 110/111 illegal)
//     x, y   W  operands, captured on the accepted start edge
//     busy   1  high from the accept edge until done
//     done   1  one-cycle pulse, result valid
//     err    1  divide-by-zero or illegal op, updated with done
//     out_h  W  high result half
//     out_l  W  low result half
//
//   Modports:
//     master  operand source (drives the request, observes the result)
//     slave   the calculator itself
// -----------------------------------------------------------------------------
interface calc_md_seq_if #(
    parameter int W = 4
);
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] out_h;
    logic [W-1:0] out_l;

    modport master (
        output start, op, x, y,
        input  busy, done, err, out_h, out_l
    );

    modport slave (
        input  start, op, x, y,
        output busy, done, err, out_h, out_l
    );
endinterface

// File: rtl/calc_md_seq.sv
// -----------------------------------------------------------------------------
// calc_md_seq
//   Parametrised sequenced calculator: single-cycle W-bit add/sub/and/xor,
//   multi-cycle unsigned shift-add multiply and unsigned restoring divide,
//   behind a start/done handshake with an internal IDLE/EXEC/FIN sequencer.
//
//   Ports:
//     clk  in  system clock, rising edge
//     rst  in  synchronous, active-high reset (aborts any operation)
//     bus  slave modport of calc_md_seq_if (start/op/x/y in,
//          busy/done/err/out_h/out_l out)
//
//   Timing (E0 = accept edge):
//     add/sub/and/xor/illegal : result registered at E1, done in the next cycle
//     mul/div                 : iterations at E1..EW, result at E(W+1)
//
//   Optional feature (macro DIV_ZERO_TRAP_EN):
//     defined   - divide by zero skips the iterations and finishes at E1
//     undefined - divide by zero runs all W iterations like any other divide
//     The result (quotient all ones, remainder = x, err = 1) is identical.
// -----------------------------------------------------------------------------
module calc_md_seq #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    calc_md_seq_if.slave bus
);

    // Iteration counter width; must be able to hold W-1.
    localparam int CW = $clog2(W) + 1;

    // Operation encodings.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b101;

    // Sequencer states.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    logic [1:0]     state;
    logic [2:0]     op_q;
    logic [W-1:0]   a_q;        // captured x
    logic [W-1:0]   b_q;        // captured y
    logic [CW-1:0]  cnt;        // iteration index, 0 .. W-1
    // Shared 2W-bit working register:
    //   mul: {partial product high, remaining multiplier bits}
    //   div: {partial remainder, remaining dividend bits / quotient bits}
    logic [2*W-1:0] acc;

    logic           busy_q;
    logic           done_q;
    logic           err_q;
    logic [W-1:0]   out_h_q;
    logic [W-1:0]   out_l_q;

    // -------------------------------------------------------------------------
    // Accept decode: where the sequencer goes after an accepted start.
    // -------------------------------------------------------------------------
    logic [1:0]     accept_state;
    logic [2*W-1:0] accept_acc;

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // so that no path leaves it unassigned and a latch is never inferred.
    always_comb begin
        accept_state = FIN;
        accept_acc   = {{W{1'b0}}, bus.x};
        if (bus.op == OP_MUL) begin
            accept_state = EXEC;
            accept_acc   = {{W{1'b0}}, bus.y};
        end else if (bus.op == OP_DIV) begin
            accept_state = EXEC;
`ifdef DIV_ZERO_TRAP_EN
            // A zero divisor has a known answer; skip the iterations.
            if (bus.y == '0) begin
                accept_state = FIN;
            end
`endif
        end
    end

    // -------------------------------------------------------------------------
    // One multiply iteration (unsigned shift-add, multiplier LSB first).
    // acc[0] is the current multiplier bit; the multiplicand is added into
    // the high half and the whole register shifts right by one.
    // -------------------------------------------------------------------------
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a_q} : {(W+1){1'b0}});
        mul_next = {mul_sum, acc[W-1:1]};
    end

    // -------------------------------------------------------------------------
    // One divide iteration (unsigned restoring, quotient MSB first).
    // The next dividend bit is shifted into the partial remainder; if the
    // divisor fits it is subtracted and a 1 quotient bit enters from the
    // right, otherwise the remainder is kept (restored) and a 0 enters.
    // The partial remainder is always below the divisor (or holds only
    // dividend bits when the divisor is zero), so the W-bit subtraction
    // never loses information.
    // -------------------------------------------------------------------------
    logic [W:0]     div_shift;
    logic           div_ge;
    logic [W-1:0]   div_rem;
    logic [2*W-1:0] div_next;

    always_comb begin
        div_shift = {acc[2*W-1:W], acc[W-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_rem   = div_ge ? (div_shift[W-1:0] - b_q) : div_shift[W-1:0];
        div_next  = {div_rem, acc[W-2:0], div_ge};
    end

    // -------------------------------------------------------------------------
    // Result selection for the FIN edge.
    // -------------------------------------------------------------------------
    logic [W:0]   add_sum;
    logic [W:0]   sub_diff;
    logic [W-1:0] res_h;
    logic [W-1:0] res_l;
    logic         res_err;

    always_comb begin
        add_sum  = {1'b0, a_q} + {1'b0, b_q};
        // Bit W of the widened difference is the borrow, i.e. (x < y).
        sub_diff = {1'b0, a_q} - {1'b0, b_q};
        res_h    = '0;
        res_l    = '0;
        res_err  = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_l    = add_sum[W-1:0];
                res_h[0] = add_sum[W];
            end
            OP_SUB: begin
                res_l    = sub_diff[W-1:0];
                res_h[0] = sub_diff[W];
            end
            OP_AND: res_l = a_q & b_q;
            OP_XOR: res_l = a_q ^ b_q;
            OP_MUL: {res_h, res_l} = acc;
            OP_DIV: begin
                res_l   = acc[W-1:0];
                res_h   = acc[2*W-1:W];
                res_err = (b_q == '0);
`ifdef DIV_ZERO_TRAP_EN
                // No iterations ran, so supply the restoring-divider answer
                // for a zero divisor directly.
                if (b_q == '0) begin
                    res_l = '1;
                    res_h = a_q;
                end
`endif
            end
            default: res_err = 1'b1;  // illegal op: zero result, error flag
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequencer and registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operand and working registers are ordinary flops, not a
            // memory, and are cleared with everything else so an aborted
            // operation leaves nothing behind.
            state   <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt     <= '0;
            acc     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            out_h_q <= '0;
            out_l_q <= '0;
        end else begin
            // done is a single-cycle pulse unless FIN raises it below.
            done_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        a_q    <= bus.x;
                        b_q    <= bus.y;
                        cnt    <= '0;
                        acc    <= accept_acc;
                        busy_q <= 1'b1;
                        state  <= accept_state;
                    end
                end

                EXEC: begin
                    acc <= (op_q == OP_MUL) ? mul_next : div_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state <= FIN;
                    end
                end

                FIN: begin
                    out_h_q <= res_h;
                    out_l_q <= res_l;
                    err_q   <= res_err;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.out_h = out_h_q;
    assign bus.out_l = out_l_q;

endmodule

// File: tb/tb_calc_md_seq.sv
// -----------------------------------------------------------------------------
// tb_calc_md_seq
//   Self-checking bench for calc_md_seq. Two instances (W=4 and W=8) share
//   clock, reset and the request fields; start is steered to one of them by
//   sel. Expected results come from an arithmetic reference model, are pushed
//   to a queue when a request is driven and popped when done is observed.
//   Honours DIV_ZERO_TRAP_EN for the expected divide-by-zero latency.
// -----------------------------------------------------------------------------
module tb_calc_md_seq;

    typedef struct {
        logic [7:0] h;
        logic [7:0] l;
        logic       err;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_c = 1'b0;
    logic [2:0] op_c = 3'b000;
    logic [7:0] x_c = '0;
    logic [7:0] y_c = '0;
    int         sel = 0;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    calc_md_seq_if #(.W(4)) if4 ();
    calc_md_seq_if #(.W(8)) if8 ();

    assign if4.start = start_c && (sel == 0);
    assign if4.op    = op_c;
    assign if4.x     = x_c[3:0];
    assign if4.y     = y_c[3:0];
    assign if8.start = start_c && (sel == 1);
    assign if8.op    = op_c;
    assign if8.x     = x_c;
    assign if8.y     = y_c;

    calc_md_seq #(.W(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    calc_md_seq #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    // Outputs of the selected instance, zero-extended to 8 bits.
    logic       busy_m, done_m, err_m;
    logic [7:0] h_m, l_m;
    always_comb begin
        busy_m = (sel == 0) ? if4.busy : if8.busy;
        done_m = (sel == 0) ? if4.done : if8.done;
        err_m  = (sel == 0) ? if4.err  : if8.err;
        h_m    = (sel == 0) ? {4'b0, if4.out_h} : if8.out_h;
        l_m    = (sel == 0) ? {4'b0, if4.out_l} : if8.out_l;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model built from plain arithmetic operators.
    function automatic exp_t model(input int w, input logic [2:0] o, input int a, input int b);
        exp_t r;
        int   mask;
        int   t;
        mask  = (1 << w) - 1;
        r.h   = '0;
        r.l   = '0;
        r.err = 1'b0;
        r.lat = 1;
        case (o)
            3'd0: begin t = a + b; r.l = 8'(t & mask); r.h = 8'(t >> w); end
            3'd1: begin r.l = 8'((a - b) & mask); r.h = (a < b) ? 8'd1 : 8'd0; end
            3'd2: r.l = 8'(a & b);
            3'd3: r.l = 8'(a ^ b);
            3'd4: begin
                t = a * b; r.l = 8'(t & mask); r.h = 8'(t >> w); r.lat = w + 1;
            end
            3'd5: begin
                r.lat = w + 1;
                if (b == 0) begin
                    r.l = 8'(mask); r.h = 8'(a); r.err = 1'b1;
`ifdef DIV_ZERO_TRAP_EN
                    r.lat = 1;
`endif
                end else begin
                    r.l = 8'(a / b); r.h = 8'(a % b);
                end
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    // Drive one request on the selected instance and score its completion.
    // poke: pulse start with other operands while the operation is busy.
    task automatic run_op(input logic [2:0] o, input int a, input int b,
                          input bit poke, input string tag);
        exp_t e;
        int   n;
        bit   seen;
        logic [7:0] h_hold, l_hold;
        exp_q.push_back(model((sel == 0) ? 4 : 8, o, a, b));
        @(negedge clk);
        op_c = o; x_c = 8'(a); y_c = 8'(b); start_c = 1'b1;
        @(posedge clk); #1;
        start_c = 1'b0;
        check({tag, "_busy"}, busy_m, 1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (poke && n == 2) begin
                start_c = 1'b1; op_c = 3'd0; x_c = 8'd1; y_c = 8'd1;
            end else if (poke && n == 3) begin
                start_c = 1'b0;
            end
            if (done_m) seen = 1'b1;
        end
        e = exp_q.pop_front();
        if (!seen) begin
            check({tag, "_done_timeout"}, 0, 1);
            return;
        end
        check({tag, "_lat"}, n, e.lat);
        check({tag, "_out_h"}, h_m, e.h);
        check({tag, "_out_l"}, l_m, e.l);
        check({tag, "_err"}, err_m, e.err);
        check({tag, "_busy_clr"}, busy_m, 0);
        h_hold = h_m;
        l_hold = l_m;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done_m, 0);
        check({tag, "_hold"}, {h_m, l_m}, {h_hold, l_hold});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        // Reset for two cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #0;
            check("rst_busy", busy_m, 0);
            check("rst_done", done_m, 0);
            check("rst_err", err_m, 0);
            check("rst_out", {h_m, l_m}, 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // W=4 directed cases.
        sel = 0;
        run_op(3'd0, 14, 3, 1'b0, "add_14_3");
        run_op(3'd1, 3, 14, 1'b0, "sub_3_14");
        run_op(3'd2, 14, 3, 1'b0, "and_14_3");
        run_op(3'd3, 14, 3, 1'b0, "xor_14_3");
        run_op(3'd4, 14, 3, 1'b1, "mul_14_3_poke");
        run_op(3'd5, 14, 3, 1'b0, "div_14_3");
        run_op(3'd5, 14, 0, 1'b0, "div_14_0");
        run_op(3'd6, 5, 6, 1'b0, "illegal_6");
        run_op(3'd7, 9, 2, 1'b0, "illegal_7");
        run_op(3'd1, 15, 0, 1'b0, "sub_15_0");
        run_op(3'd0, 15, 15, 1'b0, "add_15_15");

        // Back-to-back: start held high is accepted again in the done cycle.
        @(negedge clk);
        op_c = 3'd0; x_c = 8'd1; y_c = 8'd2; start_c = 1'b1;
        @(posedge clk); #1;                    // E0: add accepted
        op_c = 3'd3; x_c = 8'd5; y_c = 8'd3;   // start stays high
        @(posedge clk); #1;                    // E1: add finishes
        check("b2b_first_done", done_m, 1);
        check("b2b_first_out_l", l_m, 3);
        @(posedge clk); #1;                    // E2: xor accepted in done cycle
        start_c = 1'b0;
        check("b2b_second_busy", busy_m, 1);
        check("b2b_second_nodone", done_m, 0);
        @(posedge clk); #1;                    // E3: xor finishes
        check("b2b_second_done", done_m, 1);
        check("b2b_second_out_l", l_m, 6);
        @(posedge clk); #1;

        // Random W=4 operations against the model.
        for (int i = 0; i < 12; i++) begin
            run_op(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), 1'b0, "rand4");
        end

        // W=8 multiply corner.
        sel = 1;
        run_op(3'd4, 255, 255, 1'b0, "mul8_255_255");
        run_op(3'd5, 200, 7, 1'b0, "div8_200_7");
        run_op(3'd4, 255, 255, 1'b0, "mul8_255_255_again");

        // W=8 multiply aborted by reset at iteration 3.
        @(negedge clk);
        op_c = 3'd4; x_c = 8'd200; y_c = 8'd3; start_c = 1'b1;
        @(posedge clk); #1;                    // E0
        start_c = 1'b0;
        @(posedge clk);                        // E1
        @(posedge clk); #1;                    // E2
        rst = 1'b1;
        @(posedge clk); #1;                    // E3: reset instead of iteration 3
        check("abort_busy", busy_m, 0);
        check("abort_done", done_m, 0);
        check("abort_err", err_m, 0);
        check("abort_out", {h_m, l_m}, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done_m) dones++;
        end
        check("abort_no_done", dones, 0);

        // Recovery after abort.
        run_op(3'd4, 17, 13, 1'b0, "mul8_after_abort");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_md_seq.md
Name: calc_md_seq

Overview:
- Parametrised successor to the 4-bit calculator/divider/multiplier datapath.
- Folds the external control word, operand load and output mux into one block with an internal sequencer and a start/done handshake.
- Supports W-bit add/sub/and/xor in a single cycle, plus multi-cycle shift-add multiply and restoring divide.
- Sits between the operand source and the display/output registers; one clock domain.

Parameters:
- W, 4, operand width; out_h/out_l are each W bits; legal W >= 2.
- CW, derived as clog2(W)+1, iteration counter width; not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  000 add, 001 sub, 010 and, 011 xor, 100 mul, 101 div, 110/111 illegal.
- x  in  W  operand A; captured on the accepted start edge.
- y  in  W  operand B; captured on the accepted start edge.
- busy  out  1  high from the accept edge until done.
- done  out  1  one-cycle pulse; result valid.
- err  out  1  div-by-zero or illegal op; updated with done.
- out_h  out  W  high result half.
- out_l  out  W  low result half.

Behaviour:
- Reset (synchronous, active-high, clk rising edge):
  - All outputs 0; state IDLE; operand and counter registers 0.
  - rst mid-operation aborts the operation. No done is issued and outputs clear.
- FSM states are IDLE, EXEC and FIN.
- Accept (edge E0): IDLE && start.
  - Captures x, y and op.
  - busy=1, counter=0.
  - Next state is EXEC for mul/div, or FIN for ALU ops and illegal ops.
- Start while busy: ignored. Operands are not re-sampled.
- ALU ops (FIN at E1):
  - add: {out_h,out_l} = {carry in out_h[0], x+y mod 2^W}; rest of out_h = 0.
  - sub: out_l = x-y mod 2^W; out_h[0] = borrow (x<y).
  - and: out_l = x&y; out_h = 0.
  - xor: out_l = x^y; out_h = 0.
  - Latency: done high in the cycle after E1, i.e. 1 edge after accept.
- mul (unsigned shift-add):
  - One iteration per edge E1..EW.
  - FIN writes {out_h,out_l} = full 2W-bit product at E(W+1).
- div (unsigned restoring):
  - One quotient bit per edge E1..EW, MSB first.
  - FIN writes out_l = quotient, out_h = remainder at E(W+1).
- Divide by zero:
  - Result is quotient all ones and remainder = x, which is the natural restoring-divider result; err=1.
  - Latency depends on DIV_ZERO_TRAP_EN (see Optional Feature).
- Illegal op: out_h = out_l = 0, err=1, latency 1.
- FIN edge actions:
  - Registers the result and err.
  - done=1 for exactly one cycle; busy=0; state returns to IDLE.
- Back-to-back: start held high is accepted again in the cycle where done is high, i.e. the first IDLE cycle.
- Output hold: out_h, out_l and err hold between done pulses and change only at FIN or reset.

Optional Feature:
- Macro: DIV_ZERO_TRAP_EN.
- Defined:
  - div with y==0 goes directly to FIN.
  - done arrives 1 edge after accept.
  - Result and err are the same as the non-trap case.
- Undefined:
  - div by zero runs the full W iterations; latency W+1.
  - Identical result: quotient all ones, remainder x, err=1.

Test Plan:
- W=4, rst 2 cycles, then start op=add x=14 y=3 -> after 1 edge: done pulse, out_l=1, out_h=1, err=0, busy low again.
- W=4 op=sub x=3 y=14 -> out_l=5, out_h=1; op=xor x=14 y=3 -> out_l=13, out_h=0.
- W=4 op=mul x=14 y=3 -> done exactly 5 edges after accept, out_h=2, out_l=10. Pulsing start during busy changes nothing.
- W=4 op=div x=14 y=3 -> out_l=4, out_h=2, err=0, latency 5.
- W=4 op=div x=14 y=0 -> out_l=15, out_h=14, err=1. Latency 5 without DIV_ZERO_TRAP_EN, 1 with it.
- W=8 op=mul x=255 y=255 -> {out_h,out_l}=16'hFE01 at latency 9. rst asserted at iteration 3 of a second mul -> no done pulse; all outputs 0 next cycle.
